peak_window_ctrl: RTL and testbench

//  Sequencer for the peak_detection datapath. Splits the incoming sample stream into

---
 rtl/peak_pkg.sv | 22 ++
 rtl/peak_win_counter.sv | 42 ++++
 rtl/peak_window_ctrl.sv | 177 +++++++++++++++++
 tb/tb_peak_window_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared types and defaults for the peak window sequencer.
// Holds the FSM encoding and the datapath width/latency defaults.
package peak_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;
  localparam int PD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACQ,
    S_SETTLE,
    S_REPORT
  } state_e;

  // Settle counter only has to reach lat-1.
  function automatic int settle_w(int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/peak_win_counter.sv
// Window length latch and sample counter for peak_window_ctrl.
// A zero length is latched as one so every window closes.
module peak_win_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (load_i) begin
      len_d = (len_i == '0) ? CNT_W'(1) : len_i;
      cnt_d = '0;
    end else if (inc_i && (cnt_q != len_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_q - CNT_W'(1));

endmodule

// File: rtl/peak_window_ctrl.sv
// Window sequencer around the peak_detection datapath.
// Define PEAK_INDEX_EN to add the res_index output and its tracker.
module peak_window_ctrl
  import peak_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PD_LAT = PD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  win_len,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] pd_peak,
  output logic              pd_clear,
  output logic              pd_sample_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_peak,
`ifdef PEAK_INDEX_EN
  output logic [CNT_W-1:0]  res_index,
`endif
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int SW = settle_w(PD_LAT);

  state_e            state_q, state_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              rv_q, rv_d;
  logic              ovr_q, ovr_d;
  logic              load, inc, last, cap, drop;
  logic [CNT_W-1:0]  cnt;

  peak_win_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .len_i  (win_len),
    .inc_i  (inc),
    .cnt_o  (cnt),
    .last_o (last)
  );

  assign cap = (state_q == S_SETTLE) &&
               (scnt_q == SW'(PD_LAT - 1));

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    peak_d  = peak_q;
    rv_d    = rv_q;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        load    = 1'b1;
        state_d = S_ACQ;
      end
      S_ACQ: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (sample_valid) begin
          inc = 1'b1;
          if (last) begin
            state_d = S_SETTLE;
            scnt_d  = '0;
          end
        end
      end
      S_SETTLE: begin
        if (cap) begin
          peak_d  = pd_peak;
          rv_d    = 1'b1;
          state_d = S_REPORT;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = enable ? S_CLEAR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any strobe outside ACQ is lost while windows run.
  assign drop = sample_valid && enable && (state_q != S_ACQ);

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_clr)   ovr_d = 1'b0;
    else if (drop) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      peak_q  <= '0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      peak_q  <= peak_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pd_clear     = (state_q == S_CLEAR);
  assign pd_sample_en = (state_q == S_ACQ) && sample_valid;
  assign busy         = (state_q != S_IDLE);
  assign res_valid    = rv_q;
  assign res_peak     = peak_q;
  assign overrun      = ovr_q;

`ifdef PEAK_INDEX_EN
  logic [PD_LAT-1:0] iv_q;
  logic [CNT_W-1:0]  ii_q [PD_LAT];
  logic [DATA_W-1:0] best_q;
  logic              have_q;
  logic [CNT_W-1:0]  idx_q, idx_d, rix_q;
  logic              upd;

  // Sample indices ride alongside the datapath latency.
  assign upd   = iv_q[PD_LAT-1] &&
                 (!have_q || (pd_peak > best_q));
  assign idx_d = upd ? ii_q[PD_LAT-1] : idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iv_q   <= '0;
      for (int i = 0; i < PD_LAT; i++) ii_q[i] <= '0;
      best_q <= '0;
      have_q <= 1'b0;
      idx_q  <= '0;
      rix_q  <= '0;
    end else begin
      for (int i = 1; i < PD_LAT; i++) begin
        iv_q[i] <= iv_q[i-1];
        ii_q[i] <= ii_q[i-1];
      end
      iv_q[0] <= pd_sample_en;
      ii_q[0] <= cnt;
      if (load) begin
        iv_q   <= '0;
        have_q <= 1'b0;
      end else if (upd) begin
        best_q <= pd_peak;
        have_q <= 1'b1;
        idx_q  <= ii_q[PD_LAT-1];
      end
      if (cap) rix_q <= idx_d;
    end
  end

  assign res_index = rix_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

endmodule

// File: tb/tb_peak_window_ctrl.sv
// Bench for peak_window_ctrl with a behavioural peak datapath.
// Expected peaks/indices come from max over each window's samples.
module tb_peak_window_ctrl;
  import peak_pkg::*;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] win_len = '0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          res_ready = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [DW-1:0] pd_peak;
  logic          pd_clear, pd_sample_en, res_valid;
  logic [DW-1:0] res_peak;
  logic          busy, overrun;
`ifdef PEAK_INDEX_EN
  logic [CW-1:0] res_index;
`endif

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] vals[$];
  int nl;

  always #11 clk = ~clk;

  peak_window_ctrl #(
    .DATA_W (DW),
    .CNT_W  (CW),
    .PD_LAT (LAT)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enable       (enable),
    .win_len      (win_len),
    .sample_valid (sample_valid),
    .pd_peak      (pd_peak),
    .pd_clear     (pd_clear),
    .pd_sample_en (pd_sample_en),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_peak     (res_peak),
`ifdef PEAK_INDEX_EN
    .res_index    (res_index),
`endif
    .busy         (busy),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr)
  );

  // Stand-in for peak_detection: running max, LAT cycles to output.
  logic [DW-1:0] dl [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dl[i] <= '0;
    end else begin
      if (pd_clear) dl[0] <= '0;
      else if (pd_sample_en && sample > dl[0]) dl[0] <= sample;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end
  assign pd_peak = dl[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clear"}, pd_clear, 0);
    chk({tag, "_sen"}, pd_sample_en, 0);
    chk({tag, "_rv"}, res_valid, 0);
    chk({tag, "_peak"}, res_peak, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  // Entered in the CLEAR cycle; leaves in the cycle after the handshake.
  task automatic do_window(input int hold, input bit noise,
                           input int nlen);
    logic [DW-1:0] mx;
    int g;
`ifdef PEAK_INDEX_EN
    int ix;
    ix = 0;
    foreach (vals[i]) if (vals[i] > vals[ix]) ix = i;
`endif
    mx = '0;
    foreach (vals[i]) if (vals[i] > mx) mx = vals[i];
    chk("clear", pd_clear, 1);
    chk("busy", busy, 1);
    cyc();
    chk("clear_1cyc", pd_clear, 0);
    foreach (vals[i]) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        sample_valid = 1'b0;
        cyc();
      end
      sample_valid = 1'b1;
      sample = vals[i];
      #1;
      chk("sample_en", pd_sample_en, 1);
      cyc();
    end
    sample_valid = 1'b0;
    if (noise) begin
      sample_valid = 1'b1;
      sample = 16'hFFFF;
    end
    for (int k = 0; k < LAT; k++) begin
      #1;
      chk("settle_nv", res_valid, 0);
      cyc();
      sample_valid = 1'b0;
    end
    chk("res_valid", res_valid, 1);
    chk("res_peak", res_peak, mx);
`ifdef PEAK_INDEX_EN
    chk("res_index", res_index, ix);
`endif
    if (noise) chk("overrun_set", overrun, 1);
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        sample_valid = 1'($urandom_range(0, 1));
        sample = DW'($urandom);
      end
      cyc();
      chk("hold_valid", res_valid, 1);
      chk("hold_peak", res_peak, mx);
    end
    sample_valid = 1'b0;
    win_len = CW'(nlen);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("res_drop", res_valid, 0);
  endtask

  initial begin
    #(22 * 20000);
    failures++;
    $display("FAIL timeout got=0 exp=1");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (10) @(posedge clk);
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    win_len = 4;
    enable = 1'b1;
    cyc();
    vals = '{16'd3, 16'd9, 16'd5, 16'd7};
    do_window(2, 0, 20);

    vals.delete();
    for (int i = 1; i <= 19; i++) vals.push_back(DW'(i));
    vals.push_back(16'd18);
    do_window(0, 0, 20);
    vals.delete();
    for (int i = 18; i >= 1; i--) vals.push_back(DW'(i));
    vals.push_back(16'd0);
    vals.push_back(16'd0);
    do_window(0, 0, 5);

    vals.delete();
    repeat (5) vals.push_back(DW'($urandom_range(0, 16'hFFFE)));
    do_window(50, 1, 7);
    chk("ovr_sticky", overrun, 1);
    sample_valid = 1'b1;
    ovr_clr = 1'b1;
    cyc();
    sample_valid = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_clr_wins", overrun, 0);
    enable = 1'b0;
    cyc();
    chk("abort_idle", busy, 0);

    win_len = 0;
    enable = 1'b1;
    cyc();
    vals = '{16'h00A5};
    do_window(1, 0, 4);

    chk("ab_clear", pd_clear, 1);
    cyc();
    repeat (2) begin
      sample_valid = 1'b1;
      sample = 16'h0077;
      cyc();
    end
    sample_valid = 1'b0;
    enable = 1'b0;
    cyc();
    chk("ab_busy", busy, 0);
    repeat (8) begin
      sample_valid = 1'b1;
      cyc();
      chk("ab_nores", res_valid, 0);
    end
    sample_valid = 1'b0;
    chk("ab_noovr", overrun, 0);

    win_len = 3;
    enable = 1'b1;
    cyc();
    cyc();
    repeat (3) begin
      sample_valid = 1'b1;
      sample = 16'h1234;
      cyc();
    end
    sample = 16'hFFFF;
    cyc();
    sample_valid = 1'b0;
    chk("mid_ovr", overrun, 1);
    chk("mid_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    win_len = 5;
    enable = 1'b1;
    cyc();
    vals = '{16'd2, 16'd8, 16'd8, 16'd4, 16'd1};
    nl = $urandom_range(1, 8);
    do_window(0, 0, nl);

    for (int w = 0; w < 25; w++) begin
      int l, n;
      l = nl;
      n = $urandom_range(1, 8);
      vals.delete();
      for (int i = 0; i < l; i++) begin
        if ($urandom_range(0, 3) == 0) vals.push_back(DW'($urandom_range(0, 3)));
        else vals.push_back(DW'($urandom_range(0, 16'hFFFE)));
      end
      do_window($urandom_range(0, 3), 1'($urandom_range(0, 1)), n);
      nl = n;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
